// File: rtl/sa_pkg.sv
// Shared definitions for the systolic matrix-multiply engine: FSM states,
// command encodings and the accumulator width rule.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LOAD_X  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4
    } sa_state_e;

    localparam logic [1:0] CMD_NOP     = 2'b00;
    localparam logic [1:0] CMD_LOAD_W  = 2'b01;
    localparam logic [1:0] CMD_LOAD_X  = 2'b10;
    localparam logic [1:0] CMD_COMPUTE = 2'b11;

    // Wide enough that N products of two unsigned operands never overflow.
    function automatic int acc_width(input int bitwidth, input int n);
        return 2 * bitwidth + $clog2(n);
    endfunction

endpackage

// File: rtl/sa_pe.sv
// Weight-stationary processing element: holds one weight, forwards the
// activation one cell right and the updated partial sum one cell down.
module sa_pe
    import sa_pkg::*;
#(
    parameter int BITWIDTH = 4,
    parameter int ACCW     = acc_width(BITWIDTH, 4)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_ld,
    input  logic [BITWIDTH-1:0] w_in,
    input  logic [BITWIDTH-1:0] a_in,
    input  logic [ACCW-1:0]     psum_in,
    output logic [BITWIDTH-1:0] a_out,
    output logic [ACCW-1:0]     psum_out
);

    logic [BITWIDTH-1:0] w_q;
    logic [BITWIDTH-1:0] a_p1;
    logic [ACCW-1:0]     psum_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= '0;
        end else if (w_ld) begin
            w_q <= w_in;
        end
    end

    // Stage p0 -> p1: multiply-accumulate and activation hop
    always_ff @(posedge clk) begin
        a_p1    <= a_in;
        psum_p1 <= psum_in + ACCW'(w_q) * ACCW'(a_in);
    end

    assign a_out    = a_p1;
    assign psum_out = psum_p1;

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N weight-stationary systolic engine computing C = X * W from a serial
// operand stream. Build option SA_SATURATE_EN clamps results instead of wrapping.
module systolic_array_nxn
    import sa_pkg::*;
#(
    parameter int N        = 4,
    parameter int BITWIDTH = 4,
    parameter int OUTWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          cmd,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BITWIDTH-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [OUTWIDTH-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy
);

    localparam int ACCW = acc_width(BITWIDTH, N);
    localparam int RW   = $clog2(N);
    localparam int TW   = $clog2(3 * N - 2);
    localparam int EXTW = (ACCW > OUTWIDTH) ? ACCW : OUTWIDTH;
    localparam logic [TW-1:0] T_LAST = TW'(3 * N - 3);
    localparam logic [RW-1:0] IDX_LAST = RW'(N - 1);

    function automatic logic [OUTWIDTH-1:0] clip_result(input logic [ACCW-1:0] sum);
        logic [EXTW-1:0] ext;
        ext = EXTW'(sum);
`ifdef SA_SATURATE_EN
        if (ext > EXTW'({OUTWIDTH{1'b1}})) begin
            return {OUTWIDTH{1'b1}};
        end
`endif
        return OUTWIDTH'(ext);
    endfunction

    sa_state_e state_q, state_d;

    logic [RW-1:0]       row_q, col_q;
    logic [TW-1:0]       t_q;
    logic [TW-1:0]       t_p1;
    logic                vld_p1;
    logic                last_pos, w_beat, x_beat, beat;

    logic [BITWIDTH-1:0] x_mem [N][N];
    logic [OUTWIDTH-1:0] obuf  [N][N];
    logic [BITWIDTH-1:0] feed  [N];
    logic [BITWIDTH-1:0] act   [N][N];
    logic [ACCW-1:0]     psum  [N][N];

    assign last_pos = (row_q == IDX_LAST) && (col_q == IDX_LAST);
    assign w_beat   = (state_q == ST_LOAD_W) && data_valid;
    assign x_beat   = (state_q == ST_LOAD_X) && data_valid;
    assign beat     = w_beat || x_beat || ((state_q == ST_DRAIN) && result_ready);

    assign cmd_ready    = (state_q == ST_IDLE);
    assign data_ready   = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
    assign result_valid = (state_q == ST_DRAIN);
    assign busy         = (state_q != ST_IDLE);
    assign result       = (state_q == ST_DRAIN) ? obuf[row_q][col_q] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        CMD_NOP:     state_d = ST_IDLE;
                        CMD_LOAD_W:  state_d = ST_LOAD_W;
                        CMD_LOAD_X:  state_d = ST_LOAD_X;
                        CMD_COMPUTE: state_d = ST_COMPUTE;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_W, ST_LOAD_X: begin
                if (data_valid && last_pos) state_d = ST_IDLE;
            end
            ST_COMPUTE: begin
                if (t_q == T_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (result_ready && last_pos) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Row/column walk the matrix row-major for loads and drain; every state
    // is entered from IDLE, so clearing there starts each walk at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q  <= '0;
            col_q  <= '0;
            t_q    <= '0;
            t_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state_q == ST_COMPUTE);
            t_p1   <= t_q;
            if (state_q == ST_IDLE) begin
                row_q <= '0;
                col_q <= '0;
                t_q   <= '0;
            end else begin
                if (state_q == ST_COMPUTE) t_q <= t_q + 1'b1;
                if (beat) begin
                    if (col_q == IDX_LAST) begin
                        col_q <= '0;
                        row_q <= (row_q == IDX_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    x_mem[i][j] <= '0;
                end
            end
        end else if (x_beat) begin
            x_mem[row_q][col_q] <= data_in;
        end
    end

    // Skew feeder: row r sees column r of X delayed by r cycles.
    for (genvar r = 0; r < N; r++) begin : g_feed
        logic [TW-1:0] lag;
        assign lag     = t_q - TW'(r);
        assign feed[r] = ((state_q == ST_COMPUTE) && (t_q >= TW'(r)) && (lag < TW'(N)))
                         ? x_mem[lag[RW-1:0]][r] : '0;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [BITWIDTH-1:0] a_in;
            logic [ACCW-1:0]     p_in;
            logic                w_ld;

            if (c == 0) begin : g_a_edge
                assign a_in = feed[r];
            end else begin : g_a_chain
                assign a_in = act[r][c-1];
            end

            if (r == 0) begin : g_p_edge
                assign p_in = '0;
            end else begin : g_p_chain
                assign p_in = psum[r-1][c];
            end

            assign w_ld = w_beat && (row_q == RW'(r)) && (col_q == RW'(c));

            sa_pe #(
                .BITWIDTH (BITWIDTH),
                .ACCW     (ACCW)
            ) u_pe (
                .clk      (clk),
                .reset    (reset),
                .w_ld     (w_ld),
                .w_in     (data_in),
                .a_in     (a_in),
                .psum_in  (p_in),
                .a_out    (act[r][c]),
                .psum_out (psum[r][c])
            );
        end
    end

    // Activations leaving the right edge have nowhere to go.
    logic [N*BITWIDTH-1:0] act_tail;
    logic                  unused_act;
    for (genvar r = 0; r < N; r++) begin : g_tail
        assign act_tail[r*BITWIDTH +: BITWIDTH] = act[r][N-1];
    end
    assign unused_act = ^act_tail;

    // Stage p1: the bottom psum computed in cycle t_p1 holds C[t_p1-c-N+1][c];
    // the final element lands on the first DRAIN cycle, long before it is read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    obuf[i][j] <= '0;
                end
            end
        end else if (vld_p1) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (t_p1 == TW'(i + j + N - 1)) begin
                        obuf[i][j] <= clip_result(psum[N-1][j]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Randomised scoreboard bench for systolic_array_nxn: a plain matrix-product
// model predicts each result stream and a monitor checks every transfer.
module tb_systolic_array_nxn;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int OW = 8;
    localparam logic [1:0] C_NOP     = 2'b00;
    localparam logic [1:0] C_LOAD_W  = 2'b01;
    localparam logic [1:0] C_LOAD_X  = 2'b10;
    localparam logic [1:0] C_COMPUTE = 2'b11;

    typedef int mat_t [N*N];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    cmd = 2'b00;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [BW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [OW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          busy;

    systolic_array_nxn #(.N(N), .BITWIDTH(BW), .OUTWIDTH(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int w_m [N][N];
    int x_m [N][N];
    int exp_q [$];

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: C[i][c] = sum_r X[i][r] * W[r][c], then wrap or clamp to OW bits.
    function automatic int ref_c(input int i, input int c);
        int sum = 0;
        for (int r = 0; r < N; r++) sum += x_m[i][r] * w_m[r][c];
`ifdef SA_SATURATE_EN
        return (sum > (1 << OW) - 1) ? (1 << OW) - 1 : sum;
`else
        return sum % (1 << OW);
`endif
    endfunction

    // Monitor: samples on the falling edge, between driver updates.
    initial begin
        bit            stalled = 0;
        logic [OW-1:0] held = '0;
        int            e;
        forever begin
            @(negedge clk);
            if (!reset && result_valid) begin
                if (stalled) check("stall_hold", result, held);
                if (result_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious_result: got %0d, expected no transfer", result);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", result, e);
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = result;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                w_m[i][j] = 0;
                x_m[i][j] = 0;
            end
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        cmd_valid = 1'b0;
        data_valid = 1'b0;
        result_ready = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
        clear_model();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_data_ready", data_ready, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic send_cmd(input logic [1:0] c);
        int guard = 0;
        while (!cmd_ready && guard < 1000) begin
            tick();
            guard++;
        end
        if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd = C_NOP;
    endtask

    task automatic load_mat(input logic [1:0] c, input mat_t vals, input bit gaps, input int beats);
        int idx = 0;
        int cyc = 0;
        bit dv;
        send_cmd(c);
        check("load_data_ready", data_ready, 1);
        check("load_busy", busy, 1);
        while (idx < beats && cyc < 200) begin
            if (gaps && (cyc % 3 == 2)) begin
                data_valid = 1'b0;
                data_in = BW'($urandom);
            end else begin
                data_valid = 1'b1;
                data_in = BW'(vals[idx]);
            end
            dv = data_valid;
            tick();
            if (dv) idx++;
            cyc++;
        end
        data_valid = 1'b0;
        if (idx < beats) check("load_timeout", idx, beats);
        if (beats == N * N) begin
            for (int n = 0; n < N * N; n++) begin
                if (c == C_LOAD_W) w_m[n / N][n % N] = vals[n];
                else               x_m[n / N][n % N] = vals[n];
            end
            check("load_done_idle", cmd_ready, 1);
        end
    endtask

    // rmode: 0 always ready, 1 ready toggles 1,0,..., 2 random ready.
    task automatic compute_drain(input int rmode, input bit noise);
        int n = 0;
        int d = 0;
        for (int i = 0; i < N; i++)
            for (int c = 0; c < N; c++) exp_q.push_back(ref_c(i, c));
        send_cmd(C_COMPUTE);
        check("compute_busy", busy, 1);
        check("compute_data_ready", data_ready, 0);
        while (!result_valid && n < 100) begin
            cmd = C_LOAD_W;
            cmd_valid = noise;
            result_ready = 1'($urandom);
            tick();
            n++;
        end
        check("compute_latency", n + 1, 3 * N - 1);
        while (!cmd_ready && d < 500) begin
            case (rmode)
                0:       result_ready = 1'b1;
                1:       result_ready = (d % 2 == 0);
                default: result_ready = 1'($urandom);
            endcase
            cmd = C_LOAD_W;
            cmd_valid = noise;
            tick();
            d++;
        end
        cmd_valid = 1'b0;
        cmd = C_NOP;
        result_ready = 1'b0;
        check("drain_idle", cmd_ready, 1);
        // Toggling: transfers on even cycles, last at 2N^2-2, IDLE right after.
        if (rmode == 0) check("drain_cycles", d, N * N);
        if (rmode == 1) check("drain_cycles_bp", d, 2 * N * N - 1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle_noise();
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1;
            data_in = BW'($urandom);
            tick();
            check("idle_data_ready", data_ready, 0);
        end
        data_valid = 1'b0;
        check("idle_busy", busy, 0);
    endtask

    task automatic rand_mat(output mat_t m);
        for (int n = 0; n < N * N; n++) m[n] = int'($urandom_range(0, (1 << BW) - 1));
    endtask

    initial begin
        mat_t ident, seq, full, ra, rb;
        for (int n = 0; n < N * N; n++) begin
            ident[n] = (n / N == n % N) ? 1 : 0;
            seq[n]   = n;
            full[n]  = (1 << BW) - 1;
        end

        pulse_reset(2);

        // Identity weights: results reproduce X in order.
        load_mat(C_LOAD_W, ident, 0, N * N);
        load_mat(C_LOAD_X, seq, 0, N * N);
        compute_drain(0, 0);

        // Largest operands: sum 900 wraps to 132 or clamps to 255.
        load_mat(C_LOAD_W, full, 0, N * N);
        load_mat(C_LOAD_X, full, 0, N * N);
        compute_drain(0, 0);

        // Backpressure during drain.
        load_mat(C_LOAD_W, ident, 0, N * N);
        load_mat(C_LOAD_X, seq, 0, N * N);
        compute_drain(1, 0);

        // Gapped loads, then the same operands gap-free.
        rand_mat(ra);
        rand_mat(rb);
        load_mat(C_LOAD_W, ra, 1, N * N);
        load_mat(C_LOAD_X, rb, 1, N * N);
        compute_drain(0, 0);
        load_mat(C_LOAD_W, ra, 0, N * N);
        load_mat(C_LOAD_X, rb, 0, N * N);
        compute_drain(0, 0);

        // Reset after the 7th weight beat wipes W and X.
        rand_mat(ra);
        for (int n = 0; n < N * N; n++) ra[n] = ra[n] | 1;
        load_mat(C_LOAD_W, ra, 0, 7);
        pulse_reset(1);
        load_mat(C_LOAD_X, seq, 0, N * N);
        compute_drain(0, 0);

        // Ignored inputs and back-to-back computes on the same operands.
        rand_mat(ra);
        rand_mat(rb);
        load_mat(C_LOAD_W, ra, 0, N * N);
        load_mat(C_LOAD_X, rb, 0, N * N);
        idle_noise();
        compute_drain(0, 1);
        check("noise_no_load", busy, 0);
        compute_drain(0, 1);

        // Random operands with random backpressure.
        for (int k = 0; k < 3; k++) begin
            rand_mat(ra);
            rand_mat(rb);
            load_mat(C_LOAD_W, ra, 1'($urandom), N * N);
            load_mat(C_LOAD_X, rb, 1'($urandom), N * N);
            compute_drain(2, 0);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
